// File: rtl/sat_pkg.sv
// Shared types for the SAT search controller: literal encoding, FSM states,
// and the literal-width helper used by both the table and the controller.
package sat_pkg;

    localparam int MAX_VARS  = 32;
    localparam int VAR_IDX_W = 5;
    localparam int DEPTH_W   = 6;

    typedef struct packed {
        logic                 used;
        logic                 neg;
        logic [VAR_IDX_W-1:0] var_idx;
    } lit_t;

    localparam int LIT_T_W = $bits(lit_t);

    typedef enum logic [2:0] {
        ST_LOAD      = 3'd0,
        ST_IDLE      = 3'd1,
        ST_ASSIGN    = 3'd2,
        ST_WAIT      = 3'd3,
        ST_CHECK     = 3'd4,
        ST_BACKTRACK = 3'd5,
        ST_DONE      = 3'd6
    } state_t;

    function automatic int lit_w(input int num_vars);
        return 2 + $clog2(num_vars);
    endfunction

endpackage

// File: rtl/sat_literal_table.sv
// Literal table storage and load write pointer. Incoming literals are decoded
// into lit_t; a variable index outside the variable range is stored as unused.
module sat_literal_table
    import sat_pkg::*;
#(
    parameter int NUM_VARS  = 8,
    parameter int NUM_SLOTS = 48,
    localparam int LIT_W    = lit_w(NUM_VARS)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         clear,
    input  logic                         wr_en,
    input  logic [LIT_W-1:0]             wr_data,
    output logic                         last_slot,
    output logic [NUM_SLOTS*LIT_T_W-1:0] table_flat
);

    localparam int IDX_W = LIT_W - 2;
    localparam int PTR_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;

    lit_t             table_q [NUM_SLOTS];
    logic [PTR_W-1:0] wr_ptr;
    lit_t             wr_lit;

    always_comb begin
        wr_lit         = '0;
        wr_lit.var_idx = VAR_IDX_W'(wr_data[IDX_W-1:0]);
        wr_lit.neg     = wr_data[IDX_W];
        wr_lit.used    = wr_data[IDX_W+1] && (int'(wr_data[IDX_W-1:0]) < NUM_VARS);
    end

    assign last_slot = (wr_ptr == PTR_W'(NUM_SLOTS - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            for (int i = 0; i < NUM_SLOTS; i++) table_q[i] <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            for (int i = 0; i < NUM_SLOTS; i++) table_q[i] <= '0;
        end else if (wr_en) begin
            table_q[wr_ptr] <= wr_lit;
            wr_ptr          <= last_slot ? '0 : wr_ptr + 1'b1;
        end
    end

    always_comb begin
        table_flat = '0;
        for (int i = 0; i < NUM_SLOTS; i++) table_flat[i*LIT_T_W +: LIT_T_W] = table_q[i];
    end

endmodule

// File: rtl/sat_search_ctrl.sv
// DPLL-style depth-first SAT search controller driving an external clause evaluator.
// Optional conflict statistics are enabled with the SAT_SEARCH_STATS_EN macro.
module sat_search_ctrl
    import sat_pkg::*;
#(
    parameter int NUM_VARS            = 8,
    parameter int NUM_CLAUSES         = 16,
    parameter int NUM_VARS_PER_CLAUSE = 3,
    localparam int LIT_W              = lit_w(NUM_VARS)
) (
    input  logic                                       clk,
    input  logic                                       rst_n,
    input  logic                                       lit_valid,
    output logic                                       lit_ready,
    input  logic [LIT_W-1:0]                           lit_data,
    input  logic                                       load,
    input  logic                                       start,
    output logic [NUM_CLAUSES*NUM_VARS_PER_CLAUSE-1:0] clauses,
    input  logic                                       unsatisfied,
    output logic                                       busy,
    output logic                                       done,
    output logic                                       sat,
    output logic [NUM_VARS-1:0]                        model,
    output logic [15:0]                                conflicts,
    output logic [2:0]                                 fsm_state
);

    localparam int K         = NUM_VARS_PER_CLAUSE;
    localparam int NUM_SLOTS = NUM_CLAUSES * K;
    localparam logic [DEPTH_W-1:0] DEPTH_FULL = DEPTH_W'(NUM_VARS);

    // Literal stream handshake: a literal transfers on a rising edge where
    // lit_valid and lit_ready are both 1; lit_data is held while lit_valid waits.

    state_t                       state, state_next;
    logic                         loaded;
    logic [DEPTH_W-1:0]           depth, depth_m1;
    logic [MAX_VARS-1:0]          assigned, values;
    logic                         last_slot;
    logic [NUM_SLOTS*LIT_T_W-1:0] table_flat;
    logic [NUM_SLOTS-1:0]         clause_next;
    logic                         ctrl_state, load_accept, start_accept, any_used;
    lit_t                         lit;

    sat_literal_table #(
        .NUM_VARS  (NUM_VARS),
        .NUM_SLOTS (NUM_SLOTS)
    ) u_table (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (load_accept),
        .wr_en      (lit_valid && lit_ready),
        .wr_data    (lit_data),
        .last_slot  (last_slot),
        .table_flat (table_flat)
    );

    assign ctrl_state   = (state == ST_IDLE) || (state == ST_DONE);
    assign load_accept  = ctrl_state && load;
    assign start_accept = ctrl_state && start && loaded && !load;
    assign depth_m1     = depth - 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_LOAD;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_LOAD:      if (lit_valid && last_slot) state_next = ST_IDLE;
            ST_IDLE,
            ST_DONE:      if (load_accept) state_next = ST_LOAD;
                          else if (start_accept) state_next = ST_ASSIGN;
            ST_ASSIGN:    state_next = ST_WAIT;
            ST_WAIT:      state_next = ST_CHECK;
            ST_CHECK:     if (unsatisfied) state_next = ST_BACKTRACK;
                          else if (depth == DEPTH_FULL) state_next = ST_DONE;
                          else state_next = ST_ASSIGN;
            ST_BACKTRACK: if (!values[depth_m1[VAR_IDX_W-1:0]]) state_next = ST_WAIT;
                          else if (depth_m1 == '0) state_next = ST_DONE;
                          else state_next = ST_BACKTRACK;
            default:      state_next = ST_LOAD;
        endcase
    end

    always_comb begin
        lit_ready = (state == ST_LOAD);
        busy      = (state == ST_ASSIGN) || (state == ST_WAIT) ||
                    (state == ST_CHECK)  || (state == ST_BACKTRACK);
        done      = (state == ST_DONE);
        fsm_state = state;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            loaded   <= 1'b0;
            depth    <= '0;
            assigned <= '0;
            values   <= '0;
            sat      <= 1'b0;
            model    <= '0;
        end else begin
            case (state)
                ST_LOAD: if (lit_valid && last_slot) loaded <= 1'b1;
                ST_IDLE,
                ST_DONE: if (load_accept || start_accept) begin
                    loaded   <= loaded && !load_accept;
                    depth    <= '0;
                    assigned <= '0;
                    values   <= '0;
                    sat      <= 1'b0;
                    model    <= '0;
                end
                ST_ASSIGN: begin
                    assigned[depth[VAR_IDX_W-1:0]] <= 1'b1;
                    values[depth[VAR_IDX_W-1:0]]   <= 1'b0;
                    depth                          <= depth + 1'b1;
                end
                ST_CHECK: if (!unsatisfied && depth == DEPTH_FULL) begin
                    sat   <= 1'b1;
                    model <= values[NUM_VARS-1:0];
                end
                ST_BACKTRACK: if (!values[depth_m1[VAR_IDX_W-1:0]]) begin
                    values[depth_m1[VAR_IDX_W-1:0]] <= 1'b1;
                end else begin
                    assigned[depth_m1[VAR_IDX_W-1:0]] <= 1'b0;
                    values[depth_m1[VAR_IDX_W-1:0]]   <= 1'b0;
                    depth                             <= depth_m1;
                end
                default: ;
            endcase
        end
    end

    // A slot reads 1 when its literal is false; unused slots read 1 so that a clause
    // is reported all-ones only when every used literal is false. Empty clauses stay 0.
    always_comb begin
        clause_next = '0;
        any_used    = 1'b0;
        lit         = '0;
        for (int i = 0; i < NUM_CLAUSES; i++) begin
            any_used = 1'b0;
            for (int j = 0; j < K; j++) begin
                lit      = lit_t'(table_flat[(i*K+j)*LIT_T_W +: LIT_T_W]);
                any_used = any_used | lit.used;
            end
            for (int j = 0; j < K; j++) begin
                lit = lit_t'(table_flat[(i*K+j)*LIT_T_W +: LIT_T_W]);
                if (lit.used) clause_next[i*K+j] = assigned[lit.var_idx] && (values[lit.var_idx] == lit.neg);
                else          clause_next[i*K+j] = any_used;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) clauses <= '0;
        else        clauses <= clause_next;
    end

`ifdef SAT_SEARCH_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            conflicts <= '0;
        end else if (start_accept) begin
            conflicts <= '0;
        end else if (state == ST_CHECK && unsatisfied && conflicts != 16'hFFFF) begin
            conflicts <= conflicts + 16'd1;
        end
    end
`else
    assign conflicts = '0;
`endif

endmodule

// File: tb/tb_sat_search_ctrl.sv
// Scoreboard bench for sat_search_ctrl: directed literal tables with hand-derived
// search results; the bench acts as the combinational clause evaluator.
module tb_sat_search_ctrl;

    localparam int NC = 16;
    localparam int K = 3;
    localparam int SLOTS = NC * K;
    localparam logic [2:0] S_LOAD = 3'd0, S_IDLE = 3'd1, S_CHECK = 3'd4, S_DONE = 3'd6;
`ifdef SAT_SEARCH_STATS_EN
    localparam int STATS = 1;
`else
    localparam int STATS = 0;
`endif

    logic             clk, rst_n, lit_valid, lit_ready, load, start, unsatisfied;
    logic [4:0]       lit_data;
    logic [SLOTS-1:0] clauses;
    logic             busy, done, sat;
    logic [7:0]       model;
    logic [15:0]      conflicts;
    logic [2:0]       fsm_state;

    int               n_checks = 0;
    int               n_fail = 0;
    logic [24:0]      exp_q[$];
    logic [4:0]       cur_tbl [SLOTS];
    logic             done_q = 1'b0;
    logic             seen_clauses;

    sat_search_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .lit_valid   (lit_valid),
        .lit_ready   (lit_ready),
        .lit_data    (lit_data),
        .load        (load),
        .start       (start),
        .clauses     (clauses),
        .unsatisfied (unsatisfied),
        .busy        (busy),
        .done        (done),
        .sat         (sat),
        .model       (model),
        .conflicts   (conflicts),
        .fsm_state   (fsm_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Evaluator: a clause is unsatisfied when all of its literal bits are 1.
    always_comb begin
        unsatisfied = 1'b0;
        for (int i = 0; i < NC; i++) if (&clauses[i*K +: K]) unsatisfied = 1'b1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: on each rising done, pop the expected {sat, model, conflicts}.
    always @(negedge clk) begin
        logic [24:0] e;
        if (done && !done_q) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", 32'(done), 32'(1'b0));
            end else begin
                e = exp_q.pop_front();
                check("result_sat", 32'(sat), 32'(e[24]));
                check("result_model", 32'(model), 32'(e[23:16]));
                check("result_conflicts", 32'(conflicts), 32'(e[15:0]));
            end
        end
        done_q = done;
    end

    task automatic set_table(input int which);
        for (int i = 0; i < SLOTS; i++) cur_tbl[i] = 5'h00;
        case (which)
            1: cur_tbl[0] = 5'h10;
            2: begin cur_tbl[0] = 5'h10; cur_tbl[3] = 5'h18; end
            3: begin
                cur_tbl[0] = 5'h10;
                cur_tbl[3] = 5'h18; cur_tbl[4] = 5'h11;
                cur_tbl[6] = 5'h19; cur_tbl[7] = 5'h1A; cur_tbl[8] = 5'h08;
            end
            default: ;
        endcase
    endtask

    task automatic load_table(input string tag);
        int hs, extra, guard;
        hs = 0;
        extra = 0;
        @(negedge clk);
        if (fsm_state != S_LOAD) begin
            load = 1'b1;
            @(negedge clk);
            load = 1'b0;
        end
        for (int i = 0; i < SLOTS; i++) begin
            repeat ($urandom_range(0, 2)) begin
                lit_valid = 1'b0;
                @(negedge clk);
            end
            lit_valid = 1'b1;
            lit_data  = cur_tbl[i];
            guard = 0;
            while (!lit_ready && guard < 20) begin
                @(negedge clk);
                guard++;
            end
            if (lit_ready) hs++;
            @(negedge clk);
        end
        check({tag, "_ready_after_last"}, 32'(lit_ready), 32'(1'b0));
        check({tag, "_state_idle"}, 32'(fsm_state), 32'(S_IDLE));
        lit_data = 5'h1F;
        repeat (2) begin
            if (lit_ready) extra++;
            @(negedge clk);
        end
        lit_valid = 1'b0;
        check({tag, "_handshakes"}, 32'(hs), 32'd48);
        check({tag, "_extra_handshakes"}, 32'(extra), 32'd0);
    endtask

    task automatic run_search(input string tag, input logic s, input logic [7:0] m, input int c);
        int guard;
        exp_q.push_back({s, m, 16'(STATS * c)});
        seen_clauses = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        guard = 0;
        while (!done && guard < 2000) begin
            seen_clauses = seen_clauses | (|clauses);
            @(negedge clk);
            guard++;
        end
        check({tag, "_done_reached"}, 32'(done), 32'(1'b1));
        @(negedge clk);
    endtask

    initial begin
        int guard;
        rst_n = 1'b0; lit_valid = 1'b0; lit_data = '0; load = 1'b0; start = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_busy", 32'(busy), 32'(1'b0));
        check("rst_done", 32'(done), 32'(1'b0));
        check("rst_sat", 32'(sat), 32'(1'b0));
        check("rst_model", 32'(model), 32'h0);
        check("rst_conflicts", 32'(conflicts), 32'h0);
        check("rst_clauses", 32'(|clauses), 32'h0);
        check("rst_state", 32'(fsm_state), 32'(S_LOAD));
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_lit_ready", 32'(lit_ready), 32'(1'b1));

        // Single positive literal x0: one conflict, then x0=1 satisfies.
        set_table(1);
        load_table("t1");
        run_search("t1", 1'b1, 8'h01, 1);

        // x0 and !x0: both branches conflict, search exhausts.
        set_table(2);
        load_table("t2");
        run_search("t2", 1'b0, 8'h00, 2);

        // (x0)(!x0|x1)(!x1|!x2): two conflicts, model x0=x1=1.
        set_table(3);
        load_table("t3");
        run_search("t3", 1'b1, 8'h03, 2);
        repeat (5) @(negedge clk);
        check("hold_done", 32'(done), 32'(1'b1));
        check("hold_sat", 32'(sat), 32'(1'b1));
        check("hold_model", 32'(model), 32'h03);

        // start and load together in DONE: load wins and the table is wiped.
        start = 1'b1;
        load  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        load  = 1'b0;
        check("both_state", 32'(fsm_state), 32'(S_LOAD));
        check("both_done", 32'(done), 32'(1'b0));
        check("both_sat", 32'(sat), 32'(1'b0));
        check("both_lit_ready", 32'(lit_ready), 32'(1'b1));
        repeat (2) @(negedge clk);
        check("both_table_cleared", 32'(|clauses), 32'h0);

        set_table(0);
        load_table("empty");
        run_search("empty", 1'b1, 8'h00, 0);
        check("empty_clauses_zero", 32'(seen_clauses), 32'(1'b0));

        // Reset while the controller sits in CHECK.
        set_table(1);
        load_table("rst");
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        guard = 0;
        while (fsm_state != S_CHECK && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        check("pre_reset_state", 32'(fsm_state), 32'(S_CHECK));
        check("pre_reset_clauses", 32'(|clauses), 32'(1'b1));
        rst_n = 1'b0;
        #1;
        check("mid_reset_busy", 32'(busy), 32'(1'b0));
        check("mid_reset_clauses", 32'(|clauses), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("post_reset_busy", 32'(busy), 32'(1'b0));
        check("post_reset_state", 32'(fsm_state), 32'(S_LOAD));
        check("post_reset_lit_ready", 32'(lit_ready), 32'(1'b1));
        check("post_reset_done", 32'(done), 32'(1'b0));

        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
